// File: rtl/aer_event_arbiter.sv
// aer_event_arbiter: captures per-channel up/down spike edges and serialises them round-robin
// onto one four-phase req/ack AER bus with a per-phase handshake timeout.
module aer_event_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_up,
  input  logic [NUM_CH-1:0] ch_down,
  input  logic              ack,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic              down,
  output logic              go,
  output logic              busy,
  output logic [NUM_CH-1:0] ovf,
  output logic              err
);
  localparam int CW = (TIMEOUT > 256) ? $clog2(TIMEOUT) : 8;
  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;
  state_t state, state_n;
  logic [NUM_CH-1:0] up_d, dn_d, pend_up, pend_dn, up_e, dn_e, clr_up, clr_dn;
  logic [ADDR_W-1:0] ptr, win, idx;
  logic [ADDR_W:0] sum;
  logic [CW-1:0] cnt;
  logic found, win_dn, grant, tmo, to_idle, set_err;
  assign up_e = ch_up & ~up_d;
  assign dn_e = ch_down & ~dn_d;
  // Scan from ptr upward with wrap; the first channel holding any pending event wins
  always_comb begin
    win = '0;
    found = 1'b0;
    sum = '0;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, ptr} + (ADDR_W+1)'(i);
      idx = ADDR_W'(sum >= (ADDR_W+1)'(NUM_CH) ? sum - (ADDR_W+1)'(NUM_CH) : sum);
      if (!found && (pend_up[idx] || pend_dn[idx])) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  assign win_dn = ~pend_up[win];
  assign grant = state == IDLE && found;
  assign clr_up = (grant && !win_dn) ? NUM_CH'(1) << win : '0;
  assign clr_dn = (grant && win_dn) ? NUM_CH'(1) << win : '0;
  assign tmo = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
  always_comb begin
    state_n = state == IDLE ? (found ? REQ : IDLE)
            : state == REQ  ? (ack ? REL : (tmo ? IDLE : REQ))
            : state == REL  ? ((!ack || tmo) ? IDLE : REL)
            : IDLE;
  end
  assign to_idle = state != IDLE && state_n == IDLE;
  assign set_err = tmo && ((state == REQ && !ack) || (state == REL && ack));
  assign req = state == REQ;
  assign busy = state != IDLE;
  // A new edge landing in the same cycle as the grant re-arms the bit without counting as overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      up_d <= '0;
      dn_d <= '0;
      pend_up <= '0;
      pend_dn <= '0;
      ovf <= '0;
      err <= 1'b0;
      go <= 1'b0;
      cnt <= '0;
      addr <= '0;
      down <= 1'b0;
      ptr <= '0;
    end else begin
      state <= state_n;
      up_d <= ch_up;
      dn_d <= ch_down;
      pend_up <= (pend_up & ~clr_up) | up_e;
      pend_dn <= (pend_dn & ~clr_dn) | dn_e;
      ovf <= ovf | (up_e & pend_up & ~clr_up) | (dn_e & pend_dn & ~clr_dn);
      err <= err | set_err;
      go <= state == REQ && ack;
      cnt <= (state_n != state) ? '0 : cnt + CW'(1);
      if (grant) begin
        addr <= win;
        down <= win_dn;
      end
      if (to_idle) ptr <= (addr == ADDR_W'(NUM_CH - 1)) ? '0 : addr + ADDR_W'(1);
    end
  end
endmodule

// File: tb/tb_aer_event_arbiter.sv
// tb_aer_event_arbiter: directed scenarios plus random traffic, scored against a queue-based event model.
module tb_aer_event_arbiter;
  localparam int N = 4, AW = 2, TO = 8;
  logic clk = 1'b0, reset = 1'b1, ack = 1'b0;
  logic [N-1:0] ch_up = '0, ch_down = '0;
  logic req, down, go, busy, err;
  logic [AW-1:0] addr;
  logic [N-1:0] ovf;
  int n_chk = 0, n_pass = 0, go_cnt = 0;
  int ack_mode = 1;
  logic [AW:0] exp_q[$], obs_q[$], e[$];
  logic [N-1:0] m_up = '0, m_dn = '0, m_ovf = '0;
  int m_ptr = 0;

  aer_event_arbiter #(.NUM_CH(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ch_up(ch_up), .ch_down(ch_down), .ack(ack),
    .req(req), .addr(addr), .down(down), .go(go), .busy(busy), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic at(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    at(2);
    reset = 1'b0;
  endtask

  task automatic check_obs(input string nm, input logic [AW:0] ex[$]);
    check({nm, "_count"}, obs_q.size(), ex.size());
    for (int i = 0; i < ex.size(); i++)
      check(nm, i < obs_q.size() ? 32'(obs_q[i]) : 'x, 32'(ex[i]));
  endtask

  // Reference model: pending sets per channel, resolved round-robin whenever the bus starts an event
  initial begin : model
    logic [N-1:0] u, d, pu, pd, eu, ed;
    logic rs, rq_prev;
    logic [AW-1:0] kk;
    bit hit;
    pu = '0; pd = '0; rq_prev = 1'b0;
    forever begin
      @(posedge clk);
      u = ch_up; d = ch_down; rs = reset;
      #1;
      if (rs) begin
        m_up = '0; m_dn = '0; m_ovf = '0; m_ptr = 0; pu = '0; pd = '0;
      end else begin
        if (req && !rq_prev) begin
          hit = 0;
          for (int j = 0; j < N; j++) begin
            kk = AW'((m_ptr + j) % N);
            if (!hit && (m_up[kk] || m_dn[kk])) begin
              hit = 1;
              exp_q.push_back({kk, ~m_up[kk]});
              if (m_up[kk]) m_up[kk] = 1'b0;
              else m_dn[kk] = 1'b0;
              m_ptr = (int'(kk) + 1) % N;
            end
          end
          check("grant_had_pending", 32'(hit), 1);
        end
        eu = u & ~pu;
        ed = d & ~pd;
        m_ovf = m_ovf | (eu & m_up) | (ed & m_dn);
        m_up = m_up | eu;
        m_dn = m_dn | ed;
        pu = u; pd = d;
      end
      rq_prev = req;
    end
  end

  initial begin : monitor
    logic rl;
    logic [AW:0] x;
    rl = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (req && !rl) begin
        obs_q.push_back({addr, down});
        check("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          x = exp_q.pop_front();
          check("event_addr_dir", 32'({addr, down}), 32'(x));
        end
      end
      if (go) begin
        go_cnt++;
        check("go_follows_req", 32'({rl, req}), 32'b10);
      end
      rl = req;
    end
  end

  initial begin : responder
    logic rp;
    rp = 1'b0;
    forever begin
      @(negedge clk);
      ack = ack_mode == 0 ? 1'b0 : ack_mode == 1 ? rp : ($urandom_range(3) != 0 ? rp : ack);
      rp = req;
    end
  end

  initial begin : main
    int hi, g0;
    at(3);
    check("rst_req", req, 0);
    check("rst_addr", addr, 0);
    check("rst_down", down, 0);
    check("rst_go", go, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    ch_up[2] = 1'b1;
    at(1);
    check("single_c1_busy", busy, 0);
    at(1);
    check("single_c2_req", req, 1);
    check("single_c2_addr", addr, 2);
    check("single_c2_down", down, 0);
    at(1);
    check("single_c3_go", go, 0);
    at(1);
    check("single_c4_go", go, 1);
    check("single_c4_req", req, 0);
    at(1);
    check("single_c5_busy", busy, 1);
    at(1);
    check("single_c6_busy", busy, 0);
    ch_up = '0;
    at(4);

    do_reset();
    obs_q.delete();
    ch_down = 4'b1011;
    at(8);
    ch_up[0] = 1'b1;
    at(30);
    e = '{3'b001, 3'b011, 3'b111, 3'b000};
    check_obs("round_robin", e);
    ch_up = '0; ch_down = '0;
    at(2);

    obs_q.delete();
    ch_up[1] = 1'b1; ch_down[1] = 1'b1;
    at(20);
    e = '{3'b010, 3'b011};
    check_obs("same_channel", e);
    ch_up = '0; ch_down = '0;
    at(2);

    do_reset();
    obs_q.delete();
    ack_mode = 0;
    ch_up[1] = 1'b1;
    at(1); ch_up[0] = 1'b1;
    at(1); ch_up[0] = 1'b0;
    at(1); ch_up[0] = 1'b1;
    at(1); ch_up[0] = 1'b0;
    at(1); ack_mode = 1;
    at(20);
    check("ovf_flag", ovf, 4'b0001);
    check("ovf_model", ovf, m_ovf);
    e = '{3'b010, 3'b000};
    check_obs("overflow", e);
    ch_up = '0;
    at(2);

    do_reset();
    obs_q.delete();
    ack_mode = 0;
    check("to_err_clear", err, 0);
    g0 = go_cnt;
    ch_up[2] = 1'b1;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      at(1);
      if (req) hi++;
    end
    check("to_req_cycles", hi, TO);
    check("to_err_set", err, 1);
    check("to_busy", busy, 0);
    ack_mode = 1;
    ch_up[3] = 1'b1;
    at(15);
    e = '{3'b100, 3'b110};
    check_obs("timeout", e);
    check("to_go_count", go_cnt - g0, 1);
    ch_up = '0;
    at(2);

    obs_q.delete();
    ack_mode = 0;
    ch_up[0] = 1'b1; ch_up[1] = 1'b1; ch_down[2] = 1'b1;
    at(1); ch_up[1] = 1'b0;
    at(1); ch_up[1] = 1'b1;
    at(1); ch_up = '0; ch_down = '0;
    check("mid_req", req, 1);
    check("mid_ovf", ovf, 4'b0010);
    check("mid_err", err, 1);
    at(1); reset = 1'b1;
    at(1);
    check("mid_rst_req", req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_err", err, 0);
    reset = 1'b0;
    ack_mode = 1;
    at(20);
    e = '{3'b000};
    check_obs("mid_reset", e);
    check("mid_model_empty", 32'(m_up | m_dn), 0);

    do_reset();
    obs_q.delete();
    ack_mode = 2;
    for (int i = 0; i < 800; i++) begin
      at(1);
      ch_up = ch_up ^ N'($urandom & $urandom & $urandom);
      ch_down = ch_down ^ N'($urandom & $urandom & $urandom);
    end
    ch_up = '0; ch_down = '0;
    ack_mode = 1;
    for (int i = 0; i < 300 && (busy || (m_up | m_dn) != '0); i++) at(1);
    at(3);
    check("rand_drained", 32'({busy, |(m_up | m_dn)}), 0);
    check("rand_ovf", ovf, m_ovf);
    check("rand_sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
